// File: rtl/interboard_tx_sched_if.sv
// Requester and link signals of the interboard transmit scheduler.
// master = scheduler side, slave = requesters plus the link partner.
interface interboard_tx_sched_if #(
    parameter int NREQ = 2
) ();
    logic [NREQ-1:0]   req_en;
    logic [3*NREQ-1:0] req_msg_type;
    logic [5*NREQ-1:0] req_number;
    logic [NREQ-1:0]   req_busy;
    logic [NREQ-1:0]   req_done;
    logic [NREQ-1:0]   req_fail;
    logic              tx_valid;
    logic [2:0]        tx_msg_type;
    logic [4:0]        tx_number;
    logic              tx_ready;
    logic              link_err;

    modport master (
        input  req_en, req_msg_type, req_number, tx_ready,
        output req_busy, req_done, req_fail, tx_valid, tx_msg_type, tx_number, link_err
    );

    modport slave (
        output req_en, req_msg_type, req_number, tx_ready,
        input  req_busy, req_done, req_fail, tx_valid, tx_msg_type, tx_number, link_err
    );
endinterface

// File: rtl/interboard_tx_sched.sv
// Round-robin scheduler for the single interboard transmit link: one holding buffer
// per requester, valid/ready handshake with timeout/retry/drop, enforced idle gap.
module interboard_tx_sched #(
    parameter int NREQ      = 2,
    parameter int TIMEOUT   = 1000,
    parameter int MAX_RETRY = 3,
    parameter int GAP       = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_interboard_rst,
    interboard_tx_sched_if.master bus
);
    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RTRY_W = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GAP_W  = ($clog2(GAP + 1) > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_RETRY,
        S_GAP
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [IDX_W-1:0]    r_grant;
    logic [IDX_W-1:0]    w_grant_nx;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    w_ptr_nx;
    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_wait_nx;
    logic [RTRY_W-1:0]   r_retry;
    logic [RTRY_W-1:0]   w_retry_nx;
    logic [GAP_W-1:0]    r_gap;
    logic [GAP_W-1:0]    w_gap_nx;
    logic                r_link_err;
    logic                w_link_err_nx;

    logic [NREQ-1:0]     r_busy;
    logic [2:0]          r_type [NREQ];
    logic [4:0]          r_num  [NREQ];

    logic [NREQ-1:0]     w_done;
    logic [NREQ-1:0]     w_fail;
    logic [NREQ-1:0]     w_release;
    logic [NREQ-1:0]     w_take;
    logic                w_tx_valid;
    logic [IDX_W:0]      w_pick;
    logic                w_pick_vld;
    logic [IDX_W-1:0]    w_pick_idx;

    // First occupied buffer at or after the pointer; MSB flags that one was found.
    function automatic logic [IDX_W:0] f_pick(input logic [NREQ-1:0] busy,
                                              input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % NREQ);
            if (busy[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign w_pick     = f_pick(r_busy, r_ptr);
    assign w_pick_vld = w_pick[IDX_W];
    assign w_pick_idx = w_pick[IDX_W-1:0];

    always_comb begin
        w_state_nx    = r_state;
        w_grant_nx    = r_grant;
        w_ptr_nx      = r_ptr;
        w_wait_nx     = r_wait;
        w_retry_nx    = r_retry;
        w_gap_nx      = r_gap;
        w_link_err_nx = r_link_err;
        w_done        = '0;
        w_fail        = '0;
        w_tx_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_grant_nx = w_pick_idx;
                    w_ptr_nx   = IDX_W'((int'(w_pick_idx) + 1) % NREQ);
                    w_wait_nx  = '0;
                    w_state_nx = S_SEND;
                end
            end
            S_SEND: begin
                w_tx_valid = 1'b1;
                if (bus.tx_ready) begin
                    w_done[r_grant] = 1'b1;
                    w_gap_nx        = '0;
                    w_state_nx      = S_GAP;
                end else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
                    w_state_nx = S_RETRY;
                end else begin
                    w_wait_nx = r_wait + 1'b1;
                end
            end
            S_RETRY: begin
                if (r_retry < RTRY_W'(MAX_RETRY)) begin
                    w_retry_nx = r_retry + 1'b1;
                    w_wait_nx  = '0;
                    w_state_nx = S_SEND;
                end else begin
                    w_fail[r_grant] = 1'b1;
                    w_link_err_nx   = 1'b1;
                    w_gap_nx        = '0;
                    w_state_nx      = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == GAP_W'(GAP - 1)) begin
                    w_gap_nx   = '0;
                    w_wait_nx  = '0;
                    w_retry_nx = '0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_gap_nx = r_gap + 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        // An in-flight message abandoned by the synchronous clear reports nothing.
        if (i_interboard_rst) begin
            w_done = '0;
            w_fail = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_ptr      <= '0;
            r_wait     <= '0;
            r_retry    <= '0;
            r_gap      <= '0;
            r_link_err <= 1'b0;
        end else if (i_interboard_rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_ptr      <= '0;
            r_wait     <= '0;
            r_retry    <= '0;
            r_gap      <= '0;
            r_link_err <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_grant    <= w_grant_nx;
            r_ptr      <= w_ptr_nx;
            r_wait     <= w_wait_nx;
            r_retry    <= w_retry_nx;
            r_gap      <= w_gap_nx;
            r_link_err <= w_link_err_nx;
        end
    end

    // A buffer completing this cycle may be refilled in the same cycle.
    assign w_release = w_done | w_fail;
    assign w_take    = bus.req_en & (~r_busy | w_release);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else if (i_interboard_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_release) | w_take;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (w_take[i]) begin
                r_type[i] <= bus.req_msg_type[3*i +: 3];
                r_num[i]  <= bus.req_number[5*i +: 5];
            end
        end
    end

    assign bus.tx_valid    = w_tx_valid;
    assign bus.tx_msg_type = w_tx_valid ? r_type[r_grant] : 3'd0;
    assign bus.tx_number   = w_tx_valid ? r_num[r_grant] : 5'd0;
    assign bus.req_busy    = r_busy;
    assign bus.req_done    = w_done;
    assign bus.req_fail    = w_fail;
    assign bus.link_err    = r_link_err;
endmodule
